amber_timer_bank: RTL and testbench

Parametrised Wishbone timer peripheral for the Amber A23 system, replacing the single fixed timer pair. It provides NUM_TIMERS independent compare-match channels with per-channel prescaler and periodic/one-shot mode, a free-running cycle counter, a write-1-to-clear status register and maskable IRQ/FIRQ outputs. It sits as a Wishbone slave beside the core and produces `o_irq` and `o_firq`. The system level ORs these into the core's interrupt inputs.

---
 rtl/amber_timer_pkg.sv | 19 +
 rtl/amber_timer_chan.sv | 77 +++++++
 rtl/amber_timer_bank.sv | 125 ++++++++++++
 tb/tb_amber_timer_bank.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/amber_timer_pkg.sv
// Shared register map and CTRL field positions for the Amber timer bank.
package amber_timer_pkg;

   localparam logic [3:0] OFS_COUNT  = 4'h0;
   localparam logic [3:0] OFS_MATCH  = 4'h4;
   localparam logic [3:0] OFS_CTRL   = 4'h8;

   localparam logic [7:0] ADR_STATUS = 8'h80;
   localparam logic [7:0] ADR_IRQ_EN = 8'h84;
   localparam logic [7:0] ADR_FIQ_EN = 8'h88;
   localparam logic [7:0] ADR_FREE   = 8'h8C;

   localparam logic [7:0] CHAN_STRIDE = 8'h10;

   localparam int CTRL_EN_BIT       = 0;
   localparam int CTRL_ONESHOT_BIT  = 1;
   localparam int CTRL_PRESCALE_LSB = 8;

endpackage

// File: rtl/amber_timer_chan.sv
// One compare-match timer channel: prescaler, up-counter, match detect and one-shot stop.
module amber_timer_chan
   import amber_timer_pkg::*;
#(
   parameter int CNT_W      = 32,
   parameter int PRESCALE_W = 8
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_wr_count,
   input  logic        i_wr_match,
   input  logic        i_wr_ctrl,
   input  logic [31:0] i_wr_dat,
   output logic [31:0] o_count,
   output logic [31:0] o_match,
   output logic [31:0] o_ctrl,
   output logic        o_match_evt
);

   logic [CNT_W-1:0]      count;
   logic [CNT_W-1:0]      match;
   logic [PRESCALE_W-1:0] prescale;
   logic [PRESCALE_W-1:0] pre_cnt;
   logic                  en;
   logic                  oneshot;
   logic                  tick;
   logic                  wr_en;
   logic                  en_rise;
   logic                  unused_dat;

   assign wr_en      = i_wr_dat[CTRL_EN_BIT];
   assign en_rise    = i_wr_ctrl & wr_en & ~en;
   assign tick       = en & (pre_cnt == prescale);
   // A bus write to COUNT swallows the tick, including its match.
   assign o_match_evt = tick & (count == match) & ~i_wr_count;
   assign unused_dat  = ^i_wr_dat;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count    <= '0;
         match    <= '0;
         prescale <= '0;
         pre_cnt  <= '0;
         en       <= 1'b0;
         oneshot  <= 1'b0;
      end else begin
         if (i_wr_match) match <= i_wr_dat[CNT_W-1:0];

         if (i_wr_count)       count <= i_wr_dat[CNT_W-1:0];
         else if (en_rise)     count <= '0;
         else if (o_match_evt) count <= '0;
         else if (tick)        count <= count + 1'b1;

         if (en_rise || tick) pre_cnt <= '0;
         else if (en)         pre_cnt <= pre_cnt + 1'b1;

         if (i_wr_ctrl) begin
            en       <= wr_en;
            oneshot  <= i_wr_dat[CTRL_ONESHOT_BIT];
            prescale <= i_wr_dat[CTRL_PRESCALE_LSB +: PRESCALE_W];
         end else if (o_match_evt && oneshot) begin
            en <= 1'b0;
         end
      end
   end

   always_comb begin
      o_ctrl = '0;
      o_ctrl[CTRL_EN_BIT]      = en;
      o_ctrl[CTRL_ONESHOT_BIT] = oneshot;
      o_ctrl[CTRL_PRESCALE_LSB +: PRESCALE_W] = prescale;
   end

   assign o_count = 32'(count);
   assign o_match = 32'(match);

endmodule

// File: rtl/amber_timer_bank.sv
// Wishbone timer bank: NUM_TIMERS compare channels, free-running counter,
// W1C status and maskable IRQ/FIRQ reduction.
module amber_timer_bank
   import amber_timer_pkg::*;
#(
   parameter int          NUM_TIMERS = 4,
   parameter int          CNT_W      = 32,
   parameter int          PRESCALE_W = 8,
   parameter logic [31:0] BASE_ADR   = 32'hD1000000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_wb_adr,
   input  logic [3:0]  i_wb_sel,
   input  logic        i_wb_we,
   input  logic [31:0] i_wb_dat,
   input  logic        i_wb_cyc,
   input  logic        i_wb_stb,
   output logic [31:0] o_wb_dat,
   output logic        o_wb_ack,
   output logic        o_wb_err,
   output logic        o_hit,
   output logic        o_irq,
   output logic        o_firq
);

   logic                  req;
   logic                  full;
   logic                  wr;
   logic [7:0]            ofs;
   logic [31:0]           rd_dat;
   logic [31:0]           free_cnt;
   logic [NUM_TIMERS-1:0] status;
   logic [NUM_TIMERS-1:0] irq_en;
   logic [NUM_TIMERS-1:0] fiq_en;
   logic [NUM_TIMERS-1:0] w1c;
   logic [NUM_TIMERS-1:0] match_evt;
   logic [NUM_TIMERS-1:0] ch_sel;
   logic [31:0]           ch_count [NUM_TIMERS];
   logic [31:0]           ch_match [NUM_TIMERS];
   logic [31:0]           ch_ctrl  [NUM_TIMERS];
   logic                  unused_adr;

   assign o_hit      = (i_wb_adr[31:8] == BASE_ADR[31:8]);
   assign req        = i_wb_cyc & i_wb_stb & o_hit & ~o_wb_ack & ~o_wb_err;
   assign full       = (i_wb_sel == 4'b1111);
   assign wr         = req & full & i_wb_we;
   assign ofs        = {i_wb_adr[7:2], 2'b00};
   assign unused_adr = ^i_wb_adr[1:0];

   for (genvar n = 0; n < NUM_TIMERS; n++) begin : g_chan
      assign ch_sel[n] = ({ofs[7:4], 4'h0} == 8'(CHAN_STRIDE * n));

      amber_timer_chan #(
         .CNT_W      (CNT_W),
         .PRESCALE_W (PRESCALE_W)
      ) u_chan (
         .i_clk       (i_clk),
         .i_rst_n     (i_rst_n),
         .i_wr_count  (wr & ch_sel[n] & (ofs[3:0] == OFS_COUNT)),
         .i_wr_match  (wr & ch_sel[n] & (ofs[3:0] == OFS_MATCH)),
         .i_wr_ctrl   (wr & ch_sel[n] & (ofs[3:0] == OFS_CTRL)),
         .i_wr_dat    (i_wb_dat),
         .o_count     (ch_count[n]),
         .o_match     (ch_match[n]),
         .o_ctrl      (ch_ctrl[n]),
         .o_match_evt (match_evt[n])
      );
   end

   always_comb begin
      rd_dat = '0;
      case (ofs)
         ADR_STATUS: rd_dat = 32'(status);
         ADR_IRQ_EN: rd_dat = 32'(irq_en);
         ADR_FIQ_EN: rd_dat = 32'(fiq_en);
         ADR_FREE:   rd_dat = free_cnt;
         default:    ;
      endcase
      for (int n = 0; n < NUM_TIMERS; n++) begin
         if (ch_sel[n]) begin
            case (ofs[3:0])
               OFS_COUNT: rd_dat = ch_count[n];
               OFS_MATCH: rd_dat = ch_match[n];
               OFS_CTRL:  rd_dat = ch_ctrl[n];
               default:   ;
            endcase
         end
      end
   end

   // Set wins over clear so a match landing on a W1C is never lost.
   assign w1c = (wr && ofs == ADR_STATUS) ? i_wb_dat[NUM_TIMERS-1:0] : '0;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         status   <= '0;
         irq_en   <= '0;
         fiq_en   <= '0;
         free_cnt <= '0;
         o_wb_ack <= 1'b0;
         o_wb_err <= 1'b0;
         o_wb_dat <= '0;
      end else begin
         free_cnt <= free_cnt + 32'd1;
         status   <= (status & ~w1c) | match_evt;
         if (wr && ofs == ADR_IRQ_EN) irq_en <= i_wb_dat[NUM_TIMERS-1:0];
         if (wr && ofs == ADR_FIQ_EN) fiq_en <= i_wb_dat[NUM_TIMERS-1:0];

         if (req) begin
            o_wb_ack <= full;
            o_wb_err <= ~full;
            o_wb_dat <= (full && !i_wb_we) ? rd_dat : '0;
         end else begin
            o_wb_ack <= 1'b0;
            o_wb_err <= 1'b0;
            o_wb_dat <= '0;
         end
      end
   end

   assign o_irq  = |(status & irq_en);
   assign o_firq = |(status & fiq_en);

endmodule

// File: tb/tb_amber_timer_bank.sv
// Bench for amber_timer_bank: directed scenarios plus randomized channel configs
// checked against period/one-shot expectations derived from the register rules.
module tb_amber_timer_bank;

   localparam logic [31:0] BASE_A = 32'hD1000000;
   localparam logic [31:0] BASE_B = 32'hD2000000;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic [31:0] wb_adr = '0;
   logic [31:0] wb_dat = '0;
   logic [3:0]  wb_sel = '0;
   logic        wb_we = 1'b0;
   logic        wb_cyc = 1'b0;
   logic        wb_stb = 1'b0;
   logic [31:0] dat_a, dat_b;
   logic        ack_a, ack_b, err_a, err_b, hit_a, hit_b;
   logic        irq_a, irq_b, firq_a, firq_b;

   int   n_checks = 0;
   int   n_pass = 0;
   int   cyc_cnt = 0;
   int   last_wr_t = 0;
   logic irq_at_ack = 1'b0;

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc_cnt <= cyc_cnt + 1;

   amber_timer_bank #(
      .NUM_TIMERS(4), .CNT_W(32), .PRESCALE_W(8), .BASE_ADR(BASE_A)
   ) u_dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wb_adr(wb_adr), .i_wb_sel(wb_sel),
      .i_wb_we(wb_we), .i_wb_dat(wb_dat), .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb),
      .o_wb_dat(dat_a), .o_wb_ack(ack_a), .o_wb_err(err_a), .o_hit(hit_a),
      .o_irq(irq_a), .o_firq(firq_a)
   );

   amber_timer_bank #(
      .NUM_TIMERS(2), .CNT_W(8), .PRESCALE_W(8), .BASE_ADR(BASE_B)
   ) u_dut8 (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wb_adr(wb_adr), .i_wb_sel(wb_sel),
      .i_wb_we(wb_we), .i_wb_dat(wb_dat), .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb),
      .o_wb_dat(dat_b), .o_wb_ack(ack_b), .o_wb_err(err_b), .o_hit(hit_b),
      .o_irq(irq_b), .o_firq(firq_b)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
   endtask

   // One access: request, sample the ack cycle, then one idle cycle.
   task automatic wb_xfer(input logic [31:0] adr, input logic [3:0] sel, input logic we,
                          input logic [31:0] dat, output logic [31:0] rd,
                          output logic ack, output logic err);
      wb_adr = adr; wb_sel = sel; wb_we = we; wb_dat = dat;
      wb_cyc = 1'b1; wb_stb = 1'b1;
      @(posedge i_clk); #1;
      last_wr_t = cyc_cnt;
      if (adr[31:24] == BASE_B[31:24]) begin
         rd = dat_b; ack = ack_b; err = err_b; irq_at_ack = irq_b;
      end else begin
         rd = dat_a; ack = ack_a; err = err_a; irq_at_ack = irq_a;
      end
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
      @(posedge i_clk); #1;
   endtask

   task automatic wr32(input logic [31:0] adr, input logic [31:0] dat);
      logic [31:0] rd;
      logic        a, e;
      wb_xfer(adr, 4'hF, 1'b1, dat, rd, a, e);
   endtask

   task automatic rd32(input logic [31:0] adr, output logic [31:0] rd);
      logic a, e;
      wb_xfer(adr, 4'hF, 1'b0, 32'h0, rd, a, e);
   endtask

   task automatic wait_irq(input logic use_b, input int limit, output int t);
      int n = 0;
      while (!(use_b ? irq_b : irq_a) && n < limit) begin
         @(posedge i_clk); #1;
         n++;
      end
      t = cyc_cnt;
   endtask

   function automatic logic [31:0] chan_adr(input logic [31:0] base, input int ch, input int ofs);
      return base + 32'(ch * 16 + ofs);
   endfunction

   initial begin
      logic [31:0] rd, rd2;
      logic        a, e;
      int          t0, t1, t2, ch, m, p, period;
      logic        os;

      repeat (3) @(posedge i_clk); #1;
      check_val("rst_ack", 32'(ack_a), 32'h0);
      check_val("rst_err", 32'(err_a), 32'h0);
      check_val("rst_irq", 32'({irq_a, firq_a}), 32'h0);
      check_val("rst_dat", dat_a, 32'h0);
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;

      rd32(BASE_A + 32'h80, rd);
      check_val("rst_status", rd, 32'h0);
      rd32(BASE_A + 32'h8C, rd);
      rd32(BASE_A + 32'h8C, rd2);
      check_val("free_step", rd2 - rd, 32'd2);

      // Channel 0 periodic, MATCH=3, PRESCALE=0.
      wr32(BASE_A + 32'h84, 32'h1);
      wr32(chan_adr(BASE_A, 0, 4), 32'd3);
      wr32(chan_adr(BASE_A, 0, 8), 32'h1);
      t0 = last_wr_t;
      wait_irq(1'b0, 20, t1);
      check_val("c0_period", 32'(t1 - t0), 32'd4);
      wr32(BASE_A + 32'h80, 32'h1);
      check_val("c0_clear", 32'(irq_at_ack), 32'h0);
      wait_irq(1'b0, 20, t2);
      check_val("c0_reperiod", 32'(t2 - t1), 32'd4);
      wr32(BASE_A + 32'h80, 32'h1);
      @(posedge i_clk); #1;
      wr32(BASE_A + 32'h80, 32'h1);
      check_val("set_beats_clr", 32'(irq_at_ack), 32'h1);
      wr32(chan_adr(BASE_A, 0, 8), 32'h0);

      // Channel 1 one-shot, MATCH=2, PRESCALE=1.
      wr32(BASE_A + 32'h84, 32'h2);
      wr32(chan_adr(BASE_A, 1, 4), 32'd2);
      wr32(chan_adr(BASE_A, 1, 8), 32'h103);
      t0 = last_wr_t;
      wait_irq(1'b0, 30, t1);
      check_val("c1_oneshot", 32'(t1 - t0), 32'd6);
      rd32(chan_adr(BASE_A, 1, 8), rd);
      check_val("c1_ctrl", rd, 32'h102);
      rd32(chan_adr(BASE_A, 1, 0), rd);
      check_val("c1_count", rd, 32'h0);

      // IRQ / FIQ masking and W1C.
      wr32(BASE_A + 32'h84, 32'h1);
      wr32(BASE_A + 32'h88, 32'h2);
      check_val("irq_both", 32'({irq_a, firq_a}), 32'h3);
      wr32(BASE_A + 32'h80, 32'h1);
      check_val("irq_after_w1c", 32'({irq_a, firq_a}), 32'h1);
      wr32(BASE_A + 32'h80, 32'h0);
      rd32(BASE_A + 32'h80, rd);
      check_val("w1c_zero", rd, 32'h2);

      // Bus error / reserved / out of window.
      wb_xfer(BASE_A + 32'h4, 4'b0001, 1'b1, 32'hAA, rd, a, e);
      check_val("byte_err", 32'({a, e}), 32'h1);
      rd32(chan_adr(BASE_A, 0, 4), rd);
      check_val("byte_nochg", rd, 32'd3);
      wb_xfer(BASE_A + 32'hC, 4'hF, 1'b0, 32'h0, rd, a, e);
      check_val("rsvd_ack", 32'({a, e}), 32'h2);
      check_val("rsvd_dat", rd, 32'h0);
      wb_xfer(32'hD1000100, 4'hF, 1'b0, 32'h0, rd, a, e);
      check_val("outside", 32'({a, e}), 32'h0);

      // Randomized channel configurations against the period rule.
      for (int it = 0; it < 8; it++) begin
         ch = int'($urandom_range(3, 0));
         m  = int'($urandom_range(7, 1));
         p  = int'($urandom_range(3, 0));
         os = 1'($urandom_range(1, 0));
         period = (m + 1) * (p + 1);
         wr32(chan_adr(BASE_A, ch, 8), 32'h0);
         wr32(BASE_A + 32'h84, 32'(1 << ch));
         wr32(BASE_A + 32'h80, 32'hF);
         wr32(chan_adr(BASE_A, ch, 4), 32'(m));
         wr32(chan_adr(BASE_A, ch, 8), 32'((p << 8) | (int'(os) << 1) | 1));
         t0 = last_wr_t;
         wait_irq(1'b0, 100, t1);
         check_val("rnd_period", 32'(t1 - t0), 32'(period));
         wr32(BASE_A + 32'h80, 32'(1 << ch));
         check_val("rnd_clr", 32'(irq_at_ack), 32'h0);
         if (!os) begin
            wait_irq(1'b0, 100, t2);
            check_val("rnd_reperiod", 32'(t2 - t1), 32'(period));
            rd32(chan_adr(BASE_A, ch, 8), rd);
            check_val("rnd_ctrl_per", rd, 32'((p << 8) | 1));
         end else begin
            rd32(chan_adr(BASE_A, ch, 8), rd);
            check_val("rnd_ctrl_os", rd, 32'((p << 8) | 2));
            rd32(chan_adr(BASE_A, ch, 0), rd);
            check_val("rnd_count_os", rd, 32'h0);
            repeat (2 * period + 4) @(posedge i_clk);
            #1;
            check_val("rnd_os_quiet", 32'(irq_a), 32'h0);
         end
         wr32(chan_adr(BASE_A, ch, 8), 32'h0);
      end

      // 8-bit counter wrap on the second instance.
      wr32(chan_adr(BASE_B, 0, 4), 32'h12345610);
      rd32(chan_adr(BASE_B, 0, 4), rd);
      check_val("w8_match_trunc", rd, 32'h10);
      wr32(BASE_B + 32'h84, 32'h1);
      wr32(chan_adr(BASE_B, 0, 4), 32'hFF);
      wr32(chan_adr(BASE_B, 0, 8), 32'h1);
      wr32(chan_adr(BASE_B, 0, 0), 32'h20);
      t0 = last_wr_t;
      wr32(chan_adr(BASE_B, 0, 4), 32'h10);
      wait_irq(1'b1, 400, t1);
      check_val("w8_wrap", 32'(t1 - t0), 32'd241);

      // Reset in the middle of a request.
      wb_adr = BASE_A + 32'h80; wb_sel = 4'hF; wb_we = 1'b0;
      wb_cyc = 1'b1; wb_stb = 1'b1;
      #2 i_rst_n = 1'b0;
      @(posedge i_clk); #1;
      check_val("rst_mid_ack", 32'({ack_a, err_a}), 32'h0);
      wb_cyc = 1'b0; wb_stb = 1'b0;
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;
      rd32(chan_adr(BASE_A, 0, 4), rd);
      check_val("rst_mid_clr", rd, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
